alu_result_buffer: RTL and testbench

//  Downstream stage of the 64-bit shifter/ALU datapath. Captures each combinational

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_flag_gen.sv | 15 +
 rtl/alu_result_buffer.sv | 88 ++++++++
 tb/tb_alu_result_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the shifter/ALU datapath: widths and the packed layout
// of a buffered result entry {result, tag, zero, neg}.
package alu_pkg;

    localparam int ALU_WIDTH = 64;
    localparam int TAG_W     = 4;

    // Entry layout, LSB first: neg, zero, tag, result.
    localparam int NEG_BIT    = 0;
    localparam int ZERO_BIT   = 1;
    localparam int TAG_LSB    = 2;
    localparam int RESULT_LSB = TAG_LSB + TAG_W;
    localparam int ENTRY_W    = ALU_WIDTH + TAG_W + 2;

endpackage : alu_pkg

// File: rtl/alu_flag_gen.sv
// Combinational flag derivation for an ALU result; shared by several ALU stages.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg
);

    assign zero = (result == '0);
    assign neg  = result[WIDTH-1];

endmodule : alu_flag_gen

// File: rtl/alu_result_buffer.sv
// Small FIFO between the shifter/ALU result bus and register-file writeback.
// Captures result, tag and flags; valid/ready on both sides, no bypass paths.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4,
    parameter int TAG_W = alu_pkg::TAG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_result,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int E_W     = WIDTH + TAG_W + 2;
    localparam int RES_LSB = TAG_LSB + TAG_W;

    logic [E_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [E_W-1:0]   head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             in_zero;
    logic             in_neg;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flags (
        .result (in_result),
        .zero   (in_zero),
        .neg    (in_neg)
    );

    // NOTE: storage is deliberately left out of reset; empty-masking of the
    // outputs makes stale contents invisible, and the array stays plain flops.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= {in_result, in_tag, in_zero, in_neg};
        end
    end

    // NOTE: non-blocking assignments throughout so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: every output is fully assigned on both arms, so no latch can form.
    assign head       = mem[rd_ptr];
    assign out_result = empty ? '0   : head[E_W-1:RES_LSB];
    assign out_tag    = empty ? '0   : head[RES_LSB-1:TAG_LSB];
    assign out_zero   = empty ? 1'b0 : head[ZERO_BIT];
    assign out_neg    = empty ? 1'b0 : head[NEG_BIT];

endmodule : alu_result_buffer

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a queue-based FIFO model.
module tb_alu_result_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  tag;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [3:0]  out_tag;
    logic        out_zero;
    logic        out_neg;
    logic [2:0]  count;

    ent_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    alu_result_buffer #(.WIDTH(64), .DEPTH(DEPTH), .TAG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Compare every DUT output with what the queue model implies.
    task automatic check_model(input string name);
        int n = q.size();
        check({name, ".in_ready"},  64'(in_ready),  64'(n < DEPTH));
        check({name, ".out_valid"}, 64'(out_valid), 64'(n > 0));
        check({name, ".count"},     64'(count),     64'(n));
        if (n > 0) begin
            check({name, ".result"}, out_result,     q[0].res);
            check({name, ".tag"},    64'(out_tag),   64'(q[0].tag));
            check({name, ".zero"},   64'(out_zero),  64'(q[0].res == 64'd0));
            check({name, ".neg"},    64'(out_neg),   64'(q[0].res[63]));
        end else begin
            check({name, ".result"}, out_result,     64'd0);
            check({name, ".tag"},    64'(out_tag),   64'd0);
            check({name, ".zero"},   64'(out_zero),  64'd0);
            check({name, ".neg"},    64'(out_neg),   64'd0);
        end
    endtask

    // One clock: drive inputs, advance the model by the handshake rules, then
    // compare at the following falling edge. 'taken' reports producer acceptance.
    task automatic step(input bit iv, input logic [63:0] res, input logic [3:0] tg,
                        input bit ordy, input bit fl, input string name, output bit taken);
        bit do_push;
        bit do_pop;
        in_valid  = iv;
        in_result = res;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
        do_push   = iv && (q.size() < DEPTH);
        do_pop    = ordy && (q.size() > 0);
        taken     = do_push;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back('{res: res, tag: tg});
        end
        @(negedge clk);
        check_model(name);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_result = '0;
        in_tag    = '0;
        repeat (2) @(posedge clk);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        check_model("reset");
    endtask

    initial begin
        bit          tk;
        bit          pend;
        logic [63:0] pres;
        logic [3:0]  ptag;
        logic [63:0] vals[8];

        // Reset values.
        do_reset();
        check("reset.in_ready_const", 64'(in_ready), 64'd1);
        check("reset.count_const",    64'(count),    64'd0);

        // Single pass: visible the cycle after the push.
        step(1, 64'h10, 4'd3, 0, 0, "single", tk);
        check("single.result", out_result,    64'h10);
        check("single.tag",    64'(out_tag),  64'd3);
        check("single.count",  64'(count),    64'd1);

        // Fill and stall: result 5 waits until one pop frees a slot.
        do_reset();
        for (int i = 1; i <= 4; i++) step(1, 64'(i), 4'(i), 0, 0, "fill", tk);
        check("fill.count",    64'(count),    64'd4);
        check("fill.in_ready", 64'(in_ready), 64'd0);
        step(1, 64'd5, 4'd5, 0, 0, "stall", tk);
        check("stall.taken", 64'(tk), 64'd0);
        step(1, 64'd5, 4'd5, 1, 0, "stall_pop", tk);
        check("stall_pop.taken", 64'(tk),    64'd0);
        check("stall_pop.count", 64'(count), 64'd3);
        step(1, 64'd5, 4'd5, 0, 0, "stall_acc", tk);
        check("stall_acc.taken", 64'(tk),    64'd1);
        check("stall_acc.count", 64'(count), 64'd4);
        for (int i = 0; i < 5; i++) step(0, '0, '0, 1, 0, "drain", tk);

        // Wrap and order, popping every other cycle.
        vals[0] = 64'h0;
        vals[1] = 64'h8000_0000_0000_0000;
        for (int i = 2; i < 8; i++) vals[i] = {$urandom, $urandom};
        step(1, vals[0], 4'd0, 0, 0, "wrap0", tk);
        check("wrap0.zero", 64'(out_zero), 64'd1);
        begin
            int idx = 1;
            int cyc = 0;
            while (idx < 8 && cyc < 64) begin
                step(1, vals[idx], 4'(idx), cyc[0], 0, "wrap", tk);
                if (tk) idx++;
                cyc++;
            end
            check("wrap.all_pushed", 64'(idx), 64'd8);
        end
        for (int i = 0; i < 6; i++) step(0, '0, '0, 1, 0, "wrap_drain", tk);

        // Simultaneous push and pop at count 2.
        do_reset();
        step(1, 64'hA, 4'd1, 0, 0, "sim_a", tk);
        step(1, 64'hB, 4'd2, 0, 0, "sim_b", tk);
        step(1, 64'hC, 4'd3, 1, 0, "sim_pp", tk);
        check("sim.count", 64'(count), 64'd2);
        check("sim.head",  out_result, 64'hB);

        // Flush with a concurrent push: everything vanishes.
        step(1, 64'hD, 4'd4, 0, 0, "pre_flush", tk);
        check("pre_flush.count", 64'(count), 64'd3);
        step(1, 64'hDEAD, 4'd9, 0, 1, "flush", tk);
        check("flush.count",     64'(count),     64'd0);
        check("flush.out_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 0, "post_flush", tk);

        // Reset has priority over flush.
        step(1, 64'h77, 4'd7, 0, 0, "pre_rf", tk);
        rst = 1'b1;
        step(1, 64'h88, 4'd8, 0, 1, "rst_flush", tk);
        rst = 1'b0;
        check("rst_flush.count", 64'(count), 64'd0);

        // Randomized traffic; producer holds its value until accepted.
        pend = 1'b0;
        pres = '0;
        ptag = '0;
        for (int c = 0; c < 2000; c++) begin
            bit iv;
            if (!pend && ($urandom_range(0, 3) != 0)) begin
                pend = 1'b1;
                case ($urandom_range(0, 3))
                    0:       pres = 64'd0;
                    1:       pres = {1'b1, 63'($urandom)};
                    default: pres = {$urandom, $urandom};
                endcase
                ptag = 4'($urandom);
            end
            iv = pend;
            step(iv, pres, ptag, ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 63) == 0), "rand", tk);
            if (tk || flush) pend = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alu_result_buffer
